// File: rtl/bus_host_arbiter_pkg.sv
// Shared types and defaults for the bus host arbiter slice.
package bus_arb_pkg;

    localparam int NrHostsDefault        = 2;
    localparam int MaxOutstandingDefault = 2;

    // Index width for n hosts, never narrower than one bit.
    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(NrHostsDefault)-1:0] host_idx_t;

endpackage

// File: rtl/bus_host_arbiter_if.sv
// Host-side and device-side req/gnt/rvalid bundle around the bus host arbiter.
interface bus_host_arbiter_if #(
    parameter int NrHosts      = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    logic                      host_req_i    [NrHosts];
    logic                      host_gnt_o    [NrHosts];
    logic [AddressWidth-1:0]   host_addr_i   [NrHosts];
    logic                      host_we_i     [NrHosts];
    logic [DataWidth/8-1:0]    host_be_i     [NrHosts];
    logic [DataWidth-1:0]      host_wdata_i  [NrHosts];
    logic                      host_rvalid_o [NrHosts];
    logic [DataWidth-1:0]      host_rdata_o  [NrHosts];
    logic                      host_err_o    [NrHosts];

    logic                      dev_req_o;
    logic                      dev_gnt_i;
    logic [AddressWidth-1:0]   dev_addr_o;
    logic                      dev_we_o;
    logic [DataWidth/8-1:0]    dev_be_o;
    logic [DataWidth-1:0]      dev_wdata_o;
    logic                      dev_rvalid_i;
    logic [DataWidth-1:0]      dev_rdata_i;
    logic                      dev_err_i;

    // Arbiter view: serves the hosts, drives the device.
    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
    );

    // Environment view: the hosts plus the downstream device.
    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
    );

endinterface

// File: rtl/bus_host_arbiter_id_fifo.sv
// In-order FIFO of host IDs for outstanding transactions; head is the owner of the next response.
module arb_id_fifo #(
    parameter int Depth = 2,
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one device request port between bus hosts, with in-order response routing.
// Define BUS_ARB_FIXED_PRIO_EN for fixed priority (host 0 highest) instead of round-robin.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts        = NrHostsDefault,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = MaxOutstandingDefault
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    bus_host_arbiter_if.slave bus,
    output logic              spurious_o
);
    localparam int IdxW = idx_width(NrHosts);
    typedef logic [IdxW-1:0] idx_t;

    idx_t rr_ptr;
    idx_t lock_idx_q;
    idx_t win_idx;
    idx_t head_id;
    logic lock_valid_q;
    logic win_valid;
    logic accept;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic spurious_q;

    function automatic idx_t next_idx(idx_t base, int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= NrHosts) sum = sum - NrHosts;
        return idx_t'(sum);
    endfunction

    // A stalled request keeps its host until accepted, unless that host withdraws.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        if (rst_ni && !fifo_full) begin
            if (lock_valid_q && bus.host_req_i[lock_idx_q]) begin
                win_valid = 1'b1;
                win_idx   = lock_idx_q;
            end else begin
                for (int k = 0; k < NrHosts; k++) begin
                    if (!win_valid && bus.host_req_i[next_idx(rr_ptr, k)]) begin
                        win_valid = 1'b1;
                        win_idx   = next_idx(rr_ptr, k);
                    end
                end
            end
        end
    end

    assign accept          = win_valid && bus.dev_gnt_i;
    assign pop             = bus.dev_rvalid_i && !fifo_empty;
    assign bus.dev_req_o   = win_valid;
    assign bus.dev_addr_o  = win_valid ? bus.host_addr_i[win_idx]  : '0;
    assign bus.dev_we_o    = win_valid ? bus.host_we_i[win_idx]    : 1'b0;
    assign bus.dev_be_o    = win_valid ? bus.host_be_i[win_idx]    : '0;
    assign bus.dev_wdata_o = win_valid ? bus.host_wdata_i[win_idx] : '0;
    assign spurious_o      = spurious_q;

    for (genvar i = 0; i < NrHosts; i++) begin : g_host
        assign bus.host_gnt_o[i]    = accept && (win_idx == idx_t'(i));
        assign bus.host_rvalid_o[i] = pop && (head_id == idx_t'(i));
        assign bus.host_err_o[i]    = pop && (head_id == idx_t'(i)) && bus.dev_err_i;
        assign bus.host_rdata_o[i]  = bus.dev_rdata_i;
    end

`ifdef BUS_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     rr_ptr <= '0;
        else if (accept) rr_ptr <= next_idx(win_idx, 1);
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            spurious_q   <= 1'b0;
        end else begin
            lock_valid_q <= win_valid && !bus.dev_gnt_i;
            if (win_valid) lock_idx_q <= win_idx;
            if (bus.dev_rvalid_i && fifo_empty) spurious_q <= 1'b1;
        end
    end

    arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (win_idx),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_id)
    );

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Scoreboard bench for bus_host_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_bus_host_arbiter;
    import bus_arb_pkg::*;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;
    localparam int MO = MaxOutstandingDefault;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic spurious;

    bus_host_arbiter_if #(.NrHosts(N), .DataWidth(DW), .AddressWidth(AW)) bif ();

    bus_host_arbiter #(
        .NrHosts        (N),
        .DataWidth      (DW),
        .AddressWidth   (AW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bus        (bif),
        .spurious_o (spurious)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          req;
        logic [N-1:0]  gnt;
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        logic          spur;
    } cyc_t;

    typedef struct {
        int            host;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    cyc_t exp_cyc_q [$];
    rsp_t exp_rsp_q [$];

    // Reference model state: owners of outstanding transactions in issue order.
    int m_ids [$];
    int m_rr   = 0;
    int m_lock = -1;
    int m_acc  = -1;
    bit m_spur = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        cyc_t c;
        rsp_t r;
        int   w;
        c       = '{default: '0};
        w       = -1;
        m_acc   = -1;
        if (!rst_ni) begin
            m_ids.delete();
            m_rr   = 0;
            m_lock = -1;
            m_spur = 1'b0;
            exp_cyc_q.push_back(c);
            return;
        end
        c.spur = m_spur;
        if (m_lock >= 0)
            assert (bif.host_req_i[m_lock] == 1'b1)
                else $error("locked host %0d withdrew its request", m_lock);
        if (m_ids.size() < MO) begin
            if (m_lock >= 0 && bif.host_req_i[m_lock]) w = m_lock;
            else
                for (int k = 0; k < N; k++)
                    if (w < 0 && bif.host_req_i[(m_rr + k) % N]) w = (m_rr + k) % N;
        end
        if (bif.dev_rvalid_i) begin
            if (m_ids.size() > 0) begin
                r.host  = m_ids.pop_front();
                r.err   = bif.dev_err_i;
                r.rdata = bif.dev_rdata_i;
                exp_rsp_q.push_back(r);
            end else begin
                m_spur = 1'b1;
            end
        end
        if (w >= 0) begin
            c.req    = 1'b1;
            c.addr   = bif.host_addr_i[w];
            c.we     = bif.host_we_i[w];
            c.be     = bif.host_be_i[w];
            c.wdata  = bif.host_wdata_i[w];
            c.gnt[w] = bif.dev_gnt_i;
        end
        if (w >= 0 && bif.dev_gnt_i) begin
            m_ids.push_back(w);
            m_acc  = w;
`ifdef BUS_ARB_FIXED_PRIO_EN
            m_rr   = 0;
`else
            m_rr   = (w + 1) % N;
`endif
            m_lock = -1;
        end else begin
            m_lock = w;
        end
        exp_cyc_q.push_back(c);
    endtask

    // Inputs are set at posedge+1; the model consumes them and the monitor samples at negedge.
    task automatic cyc();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) bif.host_req_i[i] = 1'b0;
        bif.dev_gnt_i    = 1'b0;
        bif.dev_rvalid_i = 1'b0;
        bif.dev_err_i    = 1'b0;
        bif.dev_rdata_i  = '0;
    endtask

    task automatic set_host(int i, logic [AW-1:0] addr);
        bif.host_req_i[i]   = 1'b1;
        bif.host_addr_i[i]  = addr;
        bif.host_we_i[i]    = 1'($urandom_range(0, 1));
        bif.host_be_i[i]    = BW'($urandom);
        bif.host_wdata_i[i] = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (m_ids.size() > 0 && guard < 20) begin
            bif.dev_rvalid_i = 1'b1;
            bif.dev_rdata_i  = $urandom;
            bif.dev_err_i    = 1'($urandom_range(0, 1));
            cyc();
            guard++;
        end
        bif.dev_rvalid_i = 1'b0;
    endtask

    initial begin : monitor
        cyc_t c;
        rsp_t r;
        forever begin
            @(negedge clk_i);
            if (exp_cyc_q.size() > 0) begin
                c = exp_cyc_q.pop_front();
                check("dev_req", 64'(bif.dev_req_o), 64'(c.req));
                for (int i = 0; i < N; i++)
                    check($sformatf("host_gnt[%0d]", i), 64'(bif.host_gnt_o[i]), 64'(c.gnt[i]));
                if (c.req) begin
                    check("dev_addr", 64'(bif.dev_addr_o), 64'(c.addr));
                    check("dev_we", 64'(bif.dev_we_o), 64'(c.we));
                    check("dev_be", 64'(bif.dev_be_o), 64'(c.be));
                    check("dev_wdata", 64'(bif.dev_wdata_o), 64'(c.wdata));
                end
                check("spurious", 64'(spurious), 64'(c.spur));
            end
            for (int i = 0; i < N; i++) begin
                if (bif.host_rvalid_o[i] === 1'b1) begin
                    if (exp_rsp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_rvalid: host %0d got rvalid 1, expected 0", i);
                    end else begin
                        r = exp_rsp_q.pop_front();
                        check("rsp_host", 64'(i), 64'(r.host));
                        check("rsp_err", 64'(bif.host_err_o[i]), 64'(r.err));
                        check("rsp_rdata", 64'(bif.host_rdata_o[i]), 64'(r.rdata));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        rst_ni = 1'b0;
        idle();
        for (int i = 0; i < N; i++) set_host(i, '0);
        for (int i = 0; i < N; i++) bif.host_req_i[i] = 1'b0;
        @(posedge clk_i);
        #1;
        set_host(0, 32'h1000_0000);
        cyc();
        cyc();
        idle();
        rst_ni = 1'b1;
        cyc();

        // Both hosts requesting every cycle with the device always ready.
        set_host(0, 32'h0000_0100);
        set_host(1, 32'h0000_0200);
        bif.dev_gnt_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bif.dev_rvalid_i = (m_ids.size() > 0);
            bif.dev_rdata_i  = $urandom;
            cyc();
            if (m_acc >= 0) set_host(m_acc, AW'($urandom));
        end
        idle();
        drain();

        // Single host, response two cycles after acceptance.
        set_host(1, 32'h8000_0000);
        bif.dev_gnt_i = 1'b1;
        cyc();
        idle();
        cyc();
        bif.dev_rvalid_i = 1'b1;
        bif.dev_rdata_i  = 32'hDEAD_BEEF;
        cyc();
        idle();
        cyc();

        // Back-pressure: host 1 stalls while host 0 joins.
        set_host(1, 32'h1111_0000);
        cyc();
        set_host(0, 32'h0000_2222);
        cyc();
        cyc();
        bif.dev_gnt_i = 1'b1;
        cyc();
        bif.host_req_i[1] = 1'b0;
        cyc();
        idle();
        drain();

        // FIFO full: third request held off until a response drains one slot.
        set_host(0, 32'h0000_3000);
        bif.dev_gnt_i = 1'b1;
        cyc();
        bif.host_req_i[0] = 1'b0;
        set_host(1, 32'h0000_3100);
        cyc();
        bif.host_req_i[1] = 1'b0;
        set_host(0, 32'h0000_3200);
        cyc();
        cyc();
        bif.dev_rvalid_i = 1'b1;
        bif.dev_rdata_i  = 32'hCAFE_0001;
        cyc();
        bif.dev_rvalid_i = 1'b0;
        cyc();
        idle();
        drain();

        // Responses return to their owners in issue order with their own error flags.
        set_host(0, 32'h0000_4000);
        bif.dev_gnt_i = 1'b1;
        cyc();
        idle();
        set_host(1, 32'h0000_4100);
        bif.dev_gnt_i = 1'b1;
        cyc();
        idle();
        bif.dev_rvalid_i = 1'b1;
        bif.dev_err_i    = 1'b1;
        bif.dev_rdata_i  = 32'h0000_0A0A;
        cyc();
        bif.dev_err_i    = 1'b0;
        bif.dev_rdata_i  = 32'h0000_0B0B;
        cyc();
        idle();
        cyc();

        // Random traffic with one mid-run reset.
        for (int t = 0; t < 1500; t++) begin
            if (t == 700) rst_ni = 1'b0;
            if (t == 702) rst_ni = 1'b1;
            bif.dev_gnt_i    = ($urandom_range(0, 99) < 65);
            bif.dev_rvalid_i = rst_ni && (m_ids.size() > 0) && ($urandom_range(0, 99) < 40);
            bif.dev_err_i    = 1'($urandom_range(0, 1));
            bif.dev_rdata_i  = $urandom;
            cyc();
            for (int i = 0; i < N; i++) begin
                if (!bif.host_req_i[i] || m_acc == i) begin
                    set_host(i, AW'($urandom));
                    bif.host_req_i[i] = ($urandom_range(0, 99) < 55);
                end
            end
        end
        idle();
        drain();

        // Reset with one transaction outstanding, then a late response.
        set_host(0, 32'h0000_5000);
        bif.dev_gnt_i = 1'b1;
        cyc();
        idle();
        cyc();
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        cyc();
        bif.dev_rvalid_i = 1'b1;
        bif.dev_rdata_i  = 32'h5005_5005;
        cyc();
        idle();
        cyc();
        cyc();

        @(negedge clk_i);
        #1;
        check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
